multicycle_control_unit: RTL and testbench

- Next-generation RISC-V control unit: a multi-cycle FSM that sequences FETCH, DECODE, EXEC, MEM and WB for each instruction.
- Drives the datapath with per-state control signals and handshakes memory via req/ready, with a bounded wait.
- Adds to the single-cycle decoder: I-type ALU, JAL and illegal-opcode trapping, a memory-timeout trap and a retired-instruction counter.
- Sits between instruction/data memory and the datapath register file/ALU.

---
 rtl/multicycle_control_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, handshakes
// memory with a bounded wait, traps illegal opcodes and memory timeouts, counts retires.
module multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    input  logic             trap_clear,
    output logic             pc_write,
    output logic             ir_write,
    output logic             IorD,
    output logic             ALUSrc,
    output logic [1:0]       MemtoReg,
    output logic             Reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             branch,
    output logic [1:0]       ALUOp,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state
);

    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    // Moore control bundle; is_fetch and pc_cond are qualified by mem_ready/zero at the output.
    typedef struct packed {
        logic       pc_always;
        logic       is_fetch;
        logic       pc_cond;
        logic       iord;
        logic       alusrc;
        logic [1:0] m2r;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       br;
        logic [1:0] aop;
        logic       trp;
    } ctrl_t;

    state_e            state_r, next_state;
    logic [6:0]        op_r, next_op;
    logic [WAIT_W-1:0] wait_r, wait_next;
    logic [1:0]        cause_r, cause_next;
    logic [CNT_W-1:0]  retired_r;
    logic              retire_s;
    ctrl_t             ctrl_r;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LD, OP_ST, OP_BEQ, OP_JAL: is_legal = 1'b1;
            default:                                  is_legal = 1'b0;
        endcase
    endfunction

    function automatic ctrl_t ctrl_for(input state_e st, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.is_fetch = 1'b1;
                c.mr       = 1'b1;
            end
            S_EXEC: begin
                case (op)
                    OP_R:   c.aop = 2'b10;
                    OP_I:   begin c.aop = 2'b11; c.alusrc = 1'b1; end
                    OP_LD, OP_ST: begin c.aop = 2'b00; c.alusrc = 1'b1; end
                    OP_BEQ: begin c.aop = 2'b01; c.br = 1'b1; c.pc_cond = 1'b1; end
                    OP_JAL: c.pc_always = 1'b1;
                    default: c = '0;
                endcase
            end
            S_MEM: begin
                c.iord = 1'b1;
                c.mr   = (op == OP_LD);
                c.mw   = (op == OP_ST);
            end
            S_WB: begin
                c.rw  = 1'b1;
                c.m2r = (op == OP_LD) ? 2'b01 : ((op == OP_JAL) ? 2'b10 : 2'b00);
            end
            S_TRAP:  c.trp = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state, wait-counter, trap-cause and retire decisions.
    always_comb begin
        next_state = state_r;
        wait_next  = wait_r;
        cause_next = cause_r;
        retire_s   = 1'b0;
        next_op    = (state_r == S_DECODE) ? opcode : op_r;
        case (state_r)
            S_IDLE: begin
                if (en) begin
                    next_state = S_FETCH;
                    wait_next  = '0;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_FETCH, S_MEM: begin
                // A ready on the last allowed cycle still completes the access.
                if (mem_ready) begin
                    wait_next = '0;
                    if (state_r == S_FETCH) begin
                        next_state = S_DECODE;
                    end else if (op_r == OP_LD) begin
                        next_state = S_WB;
                    end else begin
                        next_state = S_FETCH;
                        retire_s   = 1'b1;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    next_state = S_TRAP;
                    cause_next = 2'b10;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_r + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (is_legal(opcode)) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_TRAP;
                    cause_next = 2'b01;
                end
            end
            S_EXEC: begin
                case (op_r)
                    OP_R, OP_I, OP_JAL: next_state = S_WB;
                    OP_LD, OP_ST: begin
                        next_state = S_MEM;
                        wait_next  = '0;
                    end
                    OP_BEQ: begin
                        next_state = S_FETCH;
                        wait_next  = '0;
                        retire_s   = 1'b1;
                    end
                    default: begin
                        next_state = S_TRAP;
                        cause_next = 2'b01;
                    end
                endcase
            end
            S_WB: begin
                next_state = S_FETCH;
                wait_next  = '0;
                retire_s   = 1'b1;
            end
            S_TRAP: begin
                if (trap_clear) begin
                    next_state = S_IDLE;
                    cause_next = 2'b00;
                end else begin
                    next_state = S_TRAP;
                end
            end
            default: begin
                next_state = S_IDLE;
                cause_next = 2'b00;
            end
        endcase
    end

    // State register; control bundle is precomputed for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            op_r      <= 7'd0;
            wait_r    <= '0;
            cause_r   <= 2'b00;
            retired_r <= '0;
            ctrl_r    <= '0;
        end else begin
            state_r   <= next_state;
            op_r      <= next_op;
            wait_r    <= wait_next;
            cause_r   <= cause_next;
            retired_r <= retire_s ? (retired_r + CNT_W'(1)) : retired_r;
            ctrl_r    <= ctrl_for(next_state, next_op);
        end
    end

    assign ir_write   = ctrl_r.is_fetch & mem_ready;
    assign pc_write   = ctrl_r.pc_always | (ctrl_r.is_fetch & mem_ready) | (ctrl_r.pc_cond & zero);
    assign IorD       = ctrl_r.iord;
    assign ALUSrc     = ctrl_r.alusrc;
    assign MemtoReg   = ctrl_r.m2r;
    assign Reg_write  = ctrl_r.rw;
    assign mem_read   = ctrl_r.mr;
    assign mem_write  = ctrl_r.mw;
    assign branch     = ctrl_r.br;
    assign ALUOp      = ctrl_r.aop;
    assign trap       = ctrl_r.trp;
    assign trap_cause = cause_r;
    assign retired    = retired_r;
    assign state      = state_r;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: an instruction-level model expands each randomized instruction into
// per-cycle expected observations; a negedge monitor pops and compares them.
module tb_multicycle_control_unit;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic          clk = 1'b0;
    logic          rst_n, en, zero, mem_ready, trap_clear;
    logic [6:0]    opcode;
    logic          pc_write, ir_write, IorD, ALUSrc, Reg_write, mem_read, mem_write, branch, trap;
    logic [1:0]    MemtoReg, ALUOp, trap_cause;
    logic [CW-1:0] retired;
    logic [2:0]    state;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, irw, iord, alusrc;
        logic [1:0] m2r;
        logic       rw, mr, mw, br;
        logic [1:0] aop;
        logic       trp;
        logic [1:0] cause;
        logic [3:0] ret;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_no  = 0;
    int   ret_model = 0;
    logic in_idle = 1'b1;

    always #5 clk = ~clk;

    multicycle_control_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .trap_clear(trap_clear), .pc_write(pc_write),
        .ir_write(ir_write), .IorD(IorD), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .Reg_write(Reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .ALUOp(ALUOp), .trap(trap), .trap_cause(trap_cause),
        .retired(retired), .state(state)
    );

    // Monitor: one expected observation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        obs_t e, a;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {state, pc_write, ir_write, IorD, ALUSrc, MemtoReg, Reg_write, mem_read,
                 mem_write, branch, ALUOp, trap, trap_cause, retired};
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL obs cycle %0d: got st=%0d vec=%h retired=%0d, expected st=%0d vec=%h retired=%0d",
                         cyc_no, a.st, a, a.ret, e.st, e, e.ret);
            end
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] r7();
        return 7'($urandom);
    endfunction

    function automatic logic legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) ||
               (op == OP_BEQ) || (op == OP_JAL);
    endfunction

    function automatic logic [6:0] rand_op();
        logic [6:0] t;
        case ($urandom_range(0, 6))
            0: t = OP_R;
            1: t = OP_I;
            2: t = OP_LD;
            3: t = OP_ST;
            4: t = OP_BEQ;
            5: t = OP_JAL;
            default: begin
                t = r7();
                while (legal(t)) t = r7();
            end
        endcase
        return t;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o = '0;
        o.st  = st;
        o.ret = 4'(ret_model % (2 ** CW));
        return o;
    endfunction

    task automatic step(input logic r, input logic e, input logic mr_in, input logic z,
                        input logic tc, input logic [6:0] op, input obs_t ex);
        @(posedge clk);
        #1;
        rst_n = r; en = e; mem_ready = mr_in; zero = z; trap_clear = tc; opcode = op;
        exp_q.push_back(ex);
    endtask

    task automatic idle_seq();
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, rb(), rb(), rb(), r7(), base(3'd0));
        step(1'b1, 1'b1, rb(), rb(), rb(), r7(), base(3'd0));
        in_idle = 1'b0;
    endtask

    task automatic trap_seq(input logic [1:0] cause);
        obs_t o;
        int   n;
        o = base(3'd6);
        o.trp = 1'b1;
        o.cause = cause;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) step(1'b1, rb(), rb(), rb(), 1'b0, r7(), o);
        step(1'b1, rb(), rb(), rb(), 1'b1, r7(), o);
        in_idle = 1'b1;
    endtask

    // One instruction from the FETCH state; df/dm = non-ready cycles before ready.
    task automatic run_instr(input logic [6:0] op, input logic z, input int df, input int dm,
                             input int rst_at);
        obs_t o;
        logic done, tout;
        done = 1'b0; tout = 1'b0;
        for (int i = 0; i < TO && !done; i++) begin
            o = base(3'd1); o.mr = 1'b1;
            if (i == df) begin
                o.pcw = 1'b1; o.irw = 1'b1;
                step(1'b1, rb(), 1'b1, rb(), rb(), r7(), o);
                done = 1'b1;
            end else begin
                step(1'b1, rb(), 1'b0, rb(), rb(), r7(), o);
                tout = (i == TO - 1);
            end
        end
        if (tout) begin trap_seq(2'b10); return; end
        step(1'b1, rb(), rb(), rb(), rb(), op, base(3'd2));
        if (!legal(op)) begin trap_seq(2'b01); return; end
        o = base(3'd3);
        case (op)
            OP_R:   o.aop = 2'b10;
            OP_I:   begin o.aop = 2'b11; o.alusrc = 1'b1; end
            OP_LD, OP_ST: o.alusrc = 1'b1;
            OP_BEQ: begin o.aop = 2'b01; o.br = 1'b1; o.pcw = z; end
            default: o.pcw = 1'b1;
        endcase
        step(1'b1, rb(), rb(), (op == OP_BEQ) ? z : rb(), rb(), r7(), o);
        if (op == OP_BEQ) begin ret_model++; return; end
        if (op == OP_LD || op == OP_ST) begin
            done = 1'b0;
            for (int j = 0; j < TO && !done; j++) begin
                if (j == rst_at) begin
                    ret_model = 0;
                    step(1'b0, rb(), rb(), rb(), rb(), r7(), base(3'd0));
                    in_idle = 1'b1;
                    return;
                end
                o = base(3'd4); o.iord = 1'b1;
                o.mr = (op == OP_LD); o.mw = (op == OP_ST);
                if (j == dm) begin
                    step(1'b1, rb(), 1'b1, rb(), rb(), r7(), o);
                    done = 1'b1;
                end else begin
                    step(1'b1, rb(), 1'b0, rb(), rb(), r7(), o);
                    tout = (j == TO - 1);
                end
            end
            if (tout) begin trap_seq(2'b10); return; end
            if (op == OP_ST) begin ret_model++; return; end
        end
        o = base(3'd5); o.rw = 1'b1;
        o.m2r = (op == OP_LD) ? 2'b01 : ((op == OP_JAL) ? 2'b10 : 2'b00);
        step(1'b1, rb(), rb(), rb(), rb(), r7(), o);
        ret_model++;
    endtask

    task automatic one(input logic [6:0] op, input logic z, input int df, input int dm,
                       input int rst_at);
        if (in_idle) idle_seq();
        run_instr(op, z, df, dm, rst_at);
    endtask

    task automatic random_instr();
        int df, dm;
        df = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
        dm = ($urandom_range(0, 7) == 0) ? TO : $urandom_range(0, TO - 1);
        one(rand_op(), rb(), df, dm, -1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; zero = 1'b0; mem_ready = 1'b0; trap_clear = 1'b0; opcode = 7'd0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0, base(3'd0));
        in_idle = 1'b1;
        one(OP_R,   1'b0, 0, 0, -1);
        one(OP_I,   1'b0, 1, 0, -1);
        one(OP_LD,  1'b0, 0, 3, -1);
        one(OP_ST,  1'b0, 2, 1, -1);
        one(OP_BEQ, 1'b1, 0, 0, -1);
        one(OP_BEQ, 1'b0, 0, 0, -1);
        one(OP_JAL, 1'b0, 0, 0, -1);
        one(7'b1110011, 1'b0, 0, 0, -1);
        one(OP_R,   1'b0, TO, 0, -1);
        one(OP_R,   1'b0, TO - 1, 0, -1);
        one(OP_LD,  1'b0, 0, TO, -1);
        one(OP_ST,  1'b0, 0, TO, -1);
        for (int n = 0; n < 70; n++) random_instr();
        one(OP_LD,  1'b0, 0, 3, 1);
        one(OP_R,   1'b0, 0, 0, -1);
        for (int n = 0; n < 30; n++) random_instr();
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected observations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
